// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding,
// default sizes and a helper that sizes counters from their maximum value.
package uart_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int GAP_CYCLES_DEF = 2;
    localparam int MAX_BURST_DEF  = 16;
    localparam int TIMEOUT_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } tx_state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requester with req set, searching
// upward from (last_i + 1) mod N_REQ and wrapping back to last_i itself.
module rr_priority_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    int k;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            k = (int'(last_i) + i) % N_REQ;
            if (req_i[k]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte sources: round-robin grant,
// bursts of up to MAX_BURST bytes per grant, idle gap between owners and a
// watchdog on the transmitter's done pulse.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF,
    parameter int TIMEOUT_W  = TIMEOUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    input  logic [N_REQ-1:0]        last_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic [DATA_W-1:0]       tx_data_o,
    output logic                    tx_start_o,
    input  logic                    tx_done_i,
    output logic                    timeout_o,
    output logic                    busy_o
);

    localparam int IDX_W   = cnt_w(N_REQ - 1);
    localparam int BURST_W = cnt_w(MAX_BURST);
    localparam int GAP_W   = cnt_w(GAP_CYCLES);
    // Value held in the last WAIT_DONE cycle: the counter would reach
    // all-ones on the following edge, so WAIT_DONE lasts 2^TIMEOUT_W-1 cycles.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    tx_state_e           state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                last_q, last_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                timeout_q, timeout_d;
    logic                enter_gap;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req_i),
        .last_i  (last_owner_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Next-state and datapath updates; leaving WAIT_DONE toward GAP is
    // collected in enter_gap so done-release and timeout share one path.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        tx_data_d    = tx_data_q;
        last_d       = last_q;
        burst_d      = burst_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        timeout_d    = 1'b0;
        enter_gap    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    grant_d = N_REQ'(1) << pick_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_d = data_i[int'(owner_q)*DATA_W +: DATA_W];
                last_d    = last_i[owner_q];
                burst_d   = burst_q + BURST_W'(1);
                state_d   = ST_START;
            end
            ST_START: begin
                tmo_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                tmo_d = tmo_q + TIMEOUT_W'(1);
                if (tx_done_i) begin
                    if (!last_q && req_i[owner_q] && (burst_q < BURST_W'(MAX_BURST)))
                        state_d = ST_LOAD;
                    else
                        enter_gap = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    enter_gap = 1'b1;
                end
            end
            ST_GAP: begin
                if ((GAP_W+1)'(gap_q) + (GAP_W+1)'(1) >= (GAP_W+1)'(GAP_CYCLES))
                    state_d = ST_IDLE;
                else
                    gap_d = gap_q + GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_gap) begin
            state_d      = ST_GAP;
            last_owner_d = owner_q;
            grant_d      = '0;
            burst_d      = '0;
            gap_d        = '0;
        end
    end

    // State and datapath registers; last_owner resets so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            grant_q      <= '0;
            tx_data_q    <= '0;
            last_q       <= 1'b0;
            burst_q      <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            tx_data_q    <= tx_data_d;
            last_q       <= last_d;
            burst_q      <= burst_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            timeout_q    <= timeout_d;
        end
    end

    assign ack_o      = (state_q == ST_LOAD) ? grant_q : '0;
    assign grant_o    = grant_q;
    assign tx_data_o  = tx_data_q;
    assign tx_start_o = (state_q == ST_START);
    assign timeout_o  = timeout_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
